// File: rtl/mmu_seq.sv
// mmu_seq: command sequencer for the systolic matrix-multiply unit.
// Runs LOAD_W / MATMUL / SYNC against the mmu rdy handshakes.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   cmd_valid/ready   command handshake (ready only when idle)
//   cmd_op, cmd_count 0 NOP, 1 LOAD_W, 2 MATMUL, 3 SYNC; tile count
//   weight_ld_rdy     mmu weight-load status
//   weight_ld_start   one-cycle weight-load strobe
//   mult_rdy          mmu multiply status
//   mult_run          one-cycle multiply strobe
//   busy, done, err   status; done/err are one-cycle pulses
//   tiles_done        tiles finished in current/last MATMUL
//   weights_loaded    weights valid in the array
//   err_code          0 none, 1 timeout, 2 no weights
module mmu_seq #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             weight_ld_rdy,
  output logic             weight_ld_start,
  input  logic             mult_rdy,
  output logic             mult_run,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tiles_done,
  output logic             weights_loaded,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LD_WAIT, LD_FIRE, LD_ACK, LD_DONE,
    MM_CHK, MM_WAIT, MM_FIRE, MM_ACK, MM_DONE,
    SYNC_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tiles_d, tiles_inc;
  logic wl_d, done_d, err_d;
  logic [1:0] code_d;
  logic wait_st, ld_st;

  assign tiles_inc = tiles_done + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    tiles_d = tiles_done;
    wl_d    = weights_loaded;
    code_d  = err_code;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wait_st = 1'b0;
    ld_st   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          code_d = 2'd0;
          unique case (cmd_op)
            2'd0: done_d = 1'b1;
            2'd1: begin
              state_d = LD_WAIT;
              wl_d    = 1'b0;
            end
            2'd2: begin
              state_d = MM_CHK;
              count_d = cmd_count;
              tiles_d = '0;
            end
            default: state_d = SYNC_WAIT;
          endcase
        end
      end
      LD_WAIT: begin
        wait_st = 1'b1;
        ld_st   = 1'b1;
        if (weight_ld_rdy) state_d = LD_FIRE;
      end
      LD_FIRE: state_d = LD_ACK;
      LD_ACK: begin
        wait_st = 1'b1;
        ld_st   = 1'b1;
        if (!weight_ld_rdy) state_d = LD_DONE;
      end
      LD_DONE: begin
        wait_st = 1'b1;
        ld_st   = 1'b1;
        if (weight_ld_rdy) begin
          state_d = IDLE;
          wl_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      MM_CHK: begin
        if (count_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!weights_loaded) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end else begin
          state_d = MM_WAIT;
        end
      end
      MM_WAIT: begin
        wait_st = 1'b1;
        if (mult_rdy) state_d = MM_FIRE;
      end
      MM_FIRE: state_d = MM_ACK;
      MM_ACK: begin
        wait_st = 1'b1;
        if (!mult_rdy) state_d = MM_DONE;
      end
      MM_DONE: begin
        wait_st = 1'b1;
        if (mult_rdy) begin
          tiles_d = tiles_inc;
          if (tiles_inc == count_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = MM_WAIT;
          end
        end
      end
      SYNC_WAIT: begin
        wait_st = 1'b1;
        if (weight_ld_rdy && mult_rdy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort only when this cycle made no progress
    if (wait_st && state_d == state_q) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
        code_d  = 2'd1;
        if (ld_st) wl_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    if (state_d != state_q) tmo_d = '0;
  end

  // outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tmo_q           <= '0;
      count_q         <= '0;
      tiles_done      <= '0;
      weights_loaded  <= 1'b0;
      err_code        <= 2'd0;
      done            <= 1'b0;
      err             <= 1'b0;
      weight_ld_start <= 1'b0;
      mult_run        <= 1'b0;
      busy            <= 1'b0;
      cmd_ready       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      count_q         <= count_d;
      tiles_done      <= tiles_d;
      weights_loaded  <= wl_d;
      err_code        <= code_d;
      done            <= done_d;
      err             <= err_d;
      weight_ld_start <= (state_d == LD_FIRE);
      mult_run        <= (state_d == MM_FIRE);
      busy            <= (state_d != IDLE);
      cmd_ready       <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_mmu_seq.sv
// tb_mmu_seq: self-checking bench for mmu_seq.
// Vector table, hand sequences, random commands vs model.
module tb_mmu_seq;

  localparam int CW  = 8;
  localparam int TMO = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          weight_ld_rdy;
  logic          weight_ld_start;
  logic          mult_rdy;
  logic          mult_run;
  logic          busy;
  logic          done;
  logic [CW-1:0] tiles_done;
  logic          weights_loaded;
  logic          err;
  logic [1:0]    err_code;

  mmu_seq #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .weight_ld_rdy(weight_ld_rdy),
    .weight_ld_start(weight_ld_start),
    .mult_rdy(mult_rdy),
    .mult_run(mult_run),
    .busy(busy),
    .done(done),
    .tiles_done(tiles_done),
    .weights_loaded(weights_loaded),
    .err(err),
    .err_code(err_code)
  );

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] n;
    int d;
    int e_done;
    int e_err;
    int e_code;
    int e_tiles;
    int e_wl;
    int e_ld;
    int e_mm;
    int e_first;
    int e_end;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc, ld_c, mm_c, done_c, err_c;
  int first_idx, end_idx;
  int dly = 2;
  int ld_hold = 0;
  int mm_hold = 0;
  bit stuck_ld = 0;
  bit stuck_mm = 0;
  bit m_wl;
  int m_tiles;

  logic [16:0] outs;
  assign outs = {cmd_ready, weight_ld_start, mult_run, busy,
                 done, err, weights_loaded, err_code, tiles_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mmu model: rdy drops for dly cycles after each strobe
  initial begin
    weight_ld_rdy = 1'b1;
    mult_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (ld_hold > 0) ld_hold--;
      if (mm_hold > 0) mm_hold--;
      if (weight_ld_start) ld_hold = dly;
      if (mult_run) mm_hold = dly;
      weight_ld_rdy = !stuck_ld && ld_hold == 0;
      mult_rdy = !stuck_mm && mm_hold == 0;
    end
  end

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0;
    ld_c = 0;
    mm_c = 0;
    done_c = 0;
    err_c = 0;
    first_idx = 0;
    end_idx = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    n_chk++;
    if ((done && err) || (weight_ld_start && mult_run)) begin
      n_fail++;
      $display("FAIL overlap: done=%0b err=%0b ld=%0b mm=%0b",
               done, err, weight_ld_start, mult_run);
    end
    if (weight_ld_start) ld_c++;
    if (mult_run) mm_c++;
    if ((weight_ld_start || mult_run) && first_idx == 0)
      first_idx = cyc;
    if (done) done_c++;
    if (err) err_c++;
    if ((done || err) && end_idx == 0) end_idx = cyc;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [CW-1:0] n);
    int g;
    g = 0;
    while (!cmd_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_count = n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_count = '0;
    clr();
  endtask

  task automatic run_cmd(input logic [1:0] op,
                         input logic [CW-1:0] n, input int d);
    dly = d;
    issue(op, n);
    while (end_idx == 0 && cyc < 400) sample();
    sample();
    sample();
  endtask

  task automatic check_res(input string t, input int e_done,
                           input int e_err, input int e_code,
                           input int e_tiles, input int e_wl,
                           input int e_ld, input int e_mm);
    chk({t, ".done"}, done_c, e_done);
    chk({t, ".err"}, err_c, e_err);
    chk({t, ".code"}, err_code, e_code);
    chk({t, ".tiles"}, tiles_done, e_tiles);
    chk({t, ".wl"}, weights_loaded, e_wl);
    chk({t, ".ld"}, ld_c, e_ld);
    chk({t, ".mm"}, mm_c, e_mm);
    chk({t, ".idle"}, {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    vec_t tbl[9];
    logic [1:0] bops[4];
    logic [CW-1:0] bcnt[4];
    int k, d, e_done, e_err, e_code, e_ld, e_mm;
    logic [1:0] op;
    logic [CW-1:0] n;

    tbl[0] = '{2'd2, 8'd2, 2, 0, 1, 2, 0, 0, 0, 0, 0, 2};
    tbl[1] = '{2'd0, 8'd0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2] = '{2'd1, 8'd0, 3, 1, 0, 0, 0, 1, 1, 0, 2, 6};
    tbl[3] = '{2'd2, 8'd3, 2, 1, 0, 0, 3, 1, 0, 3, 3, 14};
    tbl[4] = '{2'd2, 8'd0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 2};
    tbl[5] = '{2'd3, 8'd0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 2};
    tbl[6] = '{2'd2, 8'd1, 4, 1, 0, 0, 1, 1, 0, 1, 3, 8};
    tbl[7] = '{2'd1, 8'd0, 5, 1, 0, 0, 1, 1, 1, 0, 2, 8};
    tbl[8] = '{2'd2, 8'd5, 2, 1, 0, 0, 5, 1, 0, 5, 3, 22};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_count = '0;
    clr();
    repeat (2) @(negedge clk);
    chk("rst_outs", outs, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_outs", outs[15:0], 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_cmd(tbl[i].op, tbl[i].n, tbl[i].d);
      check_res(t, tbl[i].e_done, tbl[i].e_err, tbl[i].e_code,
                tbl[i].e_tiles, tbl[i].e_wl, tbl[i].e_ld,
                tbl[i].e_mm);
      chk({t, ".first"}, first_idx, tbl[i].e_first);
      chk({t, ".end"}, end_idx, tbl[i].e_end);
    end

    // weight load never acknowledged
    stuck_ld = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(2'd1, 8'd0, 2);
    check_res("tmo", 0, 1, 1, 5, 0, 0, 0);
    chk("tmo.end", end_idx, TMO + 1);
    stuck_ld = 1'b0;
    repeat (2) @(negedge clk);
    chk("tmo.code_held", err_code, 1);

    run_cmd(2'd1, 8'd0, 2);
    check_res("reload", 1, 0, 0, 5, 1, 1, 0);

    // reset while a 4-tile MATMUL waits in MM_ACK
    dly = 5;
    issue(2'd2, 8'd4);
    while (mm_c == 0 && cyc < 50) sample();
    sample();
    chk("mmack.state", {busy, mult_run, mm_c[1:0]}, 4'b1001);
    rst = 1'b1;
    #1;
    chk("midrst_outs", outs, 0);
    repeat (3) @(negedge clk);
    chk("midrst_hold", outs, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_rest", outs[15:0], 0);
    m_wl = 1'b0;
    m_tiles = 0;
    repeat (4) @(negedge clk);

    // SYNC waits for both mmu status lines
    stuck_mm = 1'b1;
    repeat (2) @(negedge clk);
    issue(2'd3, 8'd0);
    repeat (6) sample();
    chk("sync_hold.done", done_c, 0);
    chk("sync_hold.busy", busy, 1);
    stuck_mm = 1'b0;
    while (end_idx == 0 && cyc < 100) sample();
    sample();
    check_res("sync", 1, 0, 0, 0, 0, 0, 0);

    // back-to-back with cmd_valid held high
    bops = '{2'd0, 2'd1, 2'd3, 2'd2};
    bcnt = '{8'd0, 8'd0, 8'd0, 8'd2};
    dly = 2;
    clr();
    k = 0;
    cmd_valid = 1'b1;
    cmd_op = bops[0];
    cmd_count = bcnt[0];
    while (k < 4 && cyc < 300) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        k++;
        if (k < 4) begin
          cmd_op = bops[k];
          cmd_count = bcnt[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      sample();
    end
    while (busy && cyc < 300) sample();
    sample();
    sample();
    chk("b2b.accepted", k, 4);
    check_res("b2b", 4, 0, 0, 2, 1, 1, 2);
    m_wl = 1'b1;
    m_tiles = 2;

    // random commands against a command-level model
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      n = CW'($urandom_range(0, 5));
      d = $urandom_range(2, 5);
      op = (k == 4) ? 2'd1 : 2'(k);
      e_done = 1;
      e_err = 0;
      e_code = 0;
      e_ld = 0;
      e_mm = 0;
      if (k == 4) begin
        e_done = 0;
        e_err = 1;
        e_code = 1;
        m_wl = 1'b0;
      end else if (k == 1) begin
        e_ld = 1;
        m_wl = 1'b1;
      end else if (k == 2) begin
        m_tiles = 0;
        if (n != 0) begin
          if (!m_wl) begin
            e_done = 0;
            e_err = 1;
            e_code = 2;
          end else begin
            e_mm = n;
            m_tiles = n;
          end
        end
      end
      if (k == 4) begin
        stuck_ld = 1'b1;
        repeat (2) @(negedge clk);
      end
      run_cmd(op, n, d);
      stuck_ld = 1'b0;
      check_res($sformatf("rnd%0d", i), e_done, e_err, e_code,
                m_tiles, m_wl, e_ld, e_mm);
      repeat (2) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
